// File: rtl/alu_issue_ctrl.sv
// Issue/retire controller in front of a combinational 32-bit ALU: decodes one instruction
// per handshake, drives registered ALU inputs and returns a registered write-back/branch outcome.
module alu_issue_ctrl #(
    parameter int         XLEN   = 32,
    parameter logic [3:0] OP_ADD = 4'b0010,
    parameter logic [3:0] OP_SUB = 4'b0110,
    parameter logic [3:0] OP_AND = 4'b0000,
    parameter logic [3:0] OP_OR  = 4'b0001
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_en,
    output logic            branch_taken,
    output logic            illegal
);

    // state | meaning
    // IDLE  | in_ready high, waiting for an instruction
    // EXEC  | ALU inputs held one full cycle, result captured at the edge
    // DONE  | out_valid high, outputs frozen until out_ready

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t state;

    logic [XLEN-1:0] dec_a, dec_b;
    logic [3:0]      dec_op;
    logic            dec_illegal, dec_wb, dec_branch, dec_bne;
    logic            pend_wb, pend_branch, pend_bne;

    always_comb begin
        dec_a       = rs1_val;
        dec_b       = rs2_val;
        dec_op      = OP_ADD;
        dec_illegal = 1'b0;
        dec_wb      = 1'b0;
        dec_branch  = 1'b0;
        dec_bne     = 1'b0;
        case (opcode)
            OPC_R: begin
                dec_wb = 1'b1;
                case (funct3)
                    3'b000:  dec_op = funct7_5 ? OP_SUB : OP_ADD;
                    3'b111:  dec_op = OP_AND;
                    3'b110:  dec_op = OP_OR;
                    default: dec_illegal = 1'b1;
                endcase
            end
            OPC_I: begin
                dec_b  = imm;
                dec_wb = 1'b1;
                case (funct3)
                    3'b000:  dec_op = OP_ADD;
                    3'b111:  dec_op = OP_AND;
                    3'b110:  dec_op = OP_OR;
                    default: dec_illegal = 1'b1;
                endcase
            end
            OPC_LOAD, OPC_STORE: begin
                dec_b  = imm;
                dec_op = OP_ADD;
            end
            OPC_BRANCH: begin
                dec_op     = OP_SUB;
                dec_branch = 1'b1;
                case (funct3)
                    3'b000:  dec_bne = 1'b0;
                    3'b001:  dec_bne = 1'b1;
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
        // an illegal decode must never reach the ALU with anything but the idle add of zeros
        if (dec_illegal) begin
            dec_a      = '0;
            dec_b      = '0;
            dec_op     = OP_ADD;
            dec_wb     = 1'b0;
            dec_branch = 1'b0;
            dec_bne    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= OP_ADD;
            wb_data      <= '0;
            wb_en        <= 1'b0;
            branch_taken <= 1'b0;
            illegal      <= 1'b0;
            pend_wb      <= 1'b0;
            pend_branch  <= 1'b0;
            pend_bne     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready     <= 1'b0;
                        alu_a        <= dec_a;
                        alu_b        <= dec_b;
                        alu_op       <= dec_op;
                        wb_en        <= 1'b0;
                        branch_taken <= 1'b0;
                        wb_data      <= '0;
                        illegal      <= dec_illegal;
                        pend_wb      <= dec_wb;
                        pend_branch  <= dec_branch;
                        pend_bne     <= dec_bne;
                        if (dec_illegal) begin
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    wb_data      <= alu_result;
                    wb_en        <= pend_wb;
                    branch_taken <= pend_branch & (pend_bne ? ~alu_zero : alu_zero);
                    out_valid    <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU model on the ALU-side ports.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [31:0] rs1_val, rs2_val, imm;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] wb_data;
    logic        wb_en, branch_taken, illegal;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .wb_data(wb_data), .wb_en(wb_en), .branch_taken(branch_taken), .illegal(illegal)
    );

    always_comb begin
        case (alu_op)
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            default: alu_result = 32'hDEAD_BEEF;
        endcase
    end
    assign alu_zero = (alu_result == 32'h0);

    // the ALU only implements four codes; anything else is a fault
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            tests++;
            assert (alu_op inside {4'b0000, 4'b0001, 4'b0010, 4'b0110})
            else begin
                fails++;
                $error("FAIL alu_op_legal observed=%b expected one of 0000/0001/0010/0110", alu_op);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_alu_a"}, alu_a, 32'd0);
        chk({tag, "_alu_b"}, alu_b, 32'd0);
        chk({tag, "_alu_op"}, 32'(alu_op), 32'b0010);
        chk({tag, "_wb_data"}, wb_data, 32'd0);
        chk({tag, "_wb_en"}, 32'(wb_en), 32'd0);
        chk({tag, "_branch"}, 32'(branch_taken), 32'd0);
        chk({tag, "_illegal"}, 32'(illegal), 32'd0);
    endtask

    task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
        opcode = opc; funct3 = f3; funct7_5 = f7;
        rs1_val = a; rs2_val = b; imm = im;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic retire(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_retire_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_retire_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    // legal instruction: EXEC-cycle checks, then DONE-cycle result checks, then retire
    task automatic run_legal(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                             input logic f7, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] im, input logic [3:0] exp_op,
                             input logic [31:0] exp_data, input logic exp_wb,
                             input logic exp_taken);
        issue(opc, f3, f7, a, b, im);
        chk({tag, "_exec_alu_op"}, 32'(alu_op), 32'(exp_op));
        chk({tag, "_exec_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_exec_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_exec_illegal"}, 32'(illegal), 32'd0);
        tick();
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_wb_data"}, wb_data, exp_data);
        chk({tag, "_wb_en"}, 32'(wb_en), 32'(exp_wb));
        chk({tag, "_branch"}, 32'(branch_taken), 32'(exp_taken));
        chk({tag, "_illegal"}, 32'(illegal), 32'd0);
        retire(tag);
    endtask

    task automatic run_illegal(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                               input logic f7);
        issue(opc, f3, f7, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_illegal"}, 32'(illegal), 32'd1);
        chk({tag, "_wb_en"}, 32'(wb_en), 32'd0);
        chk({tag, "_wb_data"}, wb_data, 32'd0);
        chk({tag, "_alu_op"}, 32'(alu_op), 32'b0010);
        chk({tag, "_alu_a"}, alu_a, 32'd0);
        chk({tag, "_alu_b"}, alu_b, 32'd0);
        retire(tag);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        opcode = '0; funct3 = '0; funct7_5 = 1'b0;
        rs1_val = '0; rs2_val = '0; imm = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_reset_values("reset");

        // ADD with operand checks in EXEC
        issue(7'b0110011, 3'b000, 1'b0, 32'd5, 32'd7, 32'd0);
        chk("add_alu_a", alu_a, 32'd5);
        chk("add_alu_b", alu_b, 32'd7);
        chk("add_alu_op", 32'(alu_op), 32'b0010);
        chk("add_exec_out_valid", 32'(out_valid), 32'd0);
        tick();
        chk("add_out_valid", 32'(out_valid), 32'd1);
        chk("add_wb_data", wb_data, 32'd12);
        chk("add_wb_en", 32'(wb_en), 32'd1);
        retire("add");

        run_legal("sub_wrap", 7'b0110011, 3'b000, 1'b1, 32'd0, 32'd1, 32'd0,
                  4'b0110, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_legal("addi_wrap", 7'b0010011, 3'b000, 1'b0, 32'hFFFF_FFFF, 32'd99, 32'd1,
                  4'b0010, 32'h0, 1'b1, 1'b0);
        run_legal("and", 7'b0110011, 3'b111, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0,
                  4'b0000, 32'h00F0_00F0, 1'b1, 1'b0);
        run_legal("or", 7'b0110011, 3'b110, 1'b0, 32'hA000_0000, 32'h0000_0005, 32'd0,
                  4'b0001, 32'hA000_0005, 1'b1, 1'b0);
        run_legal("andi", 7'b0010011, 3'b111, 1'b0, 32'h1234_5678, 32'd0, 32'h0000_FF00,
                  4'b0000, 32'h0000_5600, 1'b1, 1'b0);
        run_legal("ori", 7'b0010011, 3'b110, 1'b0, 32'h0000_1200, 32'd0, 32'h0000_0034,
                  4'b0001, 32'h0000_1234, 1'b1, 1'b0);
        run_legal("load", 7'b0000011, 3'b010, 1'b0, 32'h0000_1000, 32'd0, 32'hFFFF_FFFC,
                  4'b0010, 32'h0000_0FFC, 1'b0, 1'b0);
        run_legal("store", 7'b0100011, 3'b010, 1'b0, 32'h0000_2000, 32'd77, 32'd8,
                  4'b0010, 32'h0000_2008, 1'b0, 1'b0);
        run_legal("beq_eq", 7'b1100011, 3'b000, 1'b0, 32'h1234, 32'h1234, 32'd0,
                  4'b0110, 32'h0, 1'b0, 1'b1);
        run_legal("bne_eq", 7'b1100011, 3'b001, 1'b0, 32'h1234, 32'h1234, 32'd0,
                  4'b0110, 32'h0, 1'b0, 1'b0);
        run_legal("bne_ne", 7'b1100011, 3'b001, 1'b0, 32'd5, 32'd3, 32'd0,
                  4'b0110, 32'd2, 1'b0, 1'b1);
        run_legal("beq_ne", 7'b1100011, 3'b000, 1'b0, 32'd5, 32'd3, 32'd0,
                  4'b0110, 32'd2, 1'b0, 1'b0);

        run_illegal("ill_system", 7'b1110011, 3'b000, 1'b0);
        run_illegal("ill_r_f3", 7'b0110011, 3'b010, 1'b0);
        run_illegal("ill_i_f3", 7'b0010011, 3'b001, 1'b0);
        run_illegal("ill_br_f3", 7'b1100011, 3'b100, 1'b0);

        // legal instruction after an illegal one must clear the flag
        run_legal("after_ill", 7'b0110011, 3'b000, 1'b0, 32'd1, 32'd1, 32'd0,
                  4'b0010, 32'd2, 1'b1, 1'b0);

        // downstream stall: outputs frozen, new requests ignored
        issue(7'b0110011, 3'b000, 1'b0, 32'd1, 32'd2, 32'd0);
        tick();
        opcode = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b1;
        rs1_val = 32'd100; rs2_val = 32'd50; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_wb_data", wb_data, 32'd3);
            chk("stall_wb_en", 32'(wb_en), 32'd1);
            chk("stall_alu_op", 32'(alu_op), 32'b0010);
            chk("stall_alu_a", alu_a, 32'd1);
            tick();
        end
        in_valid = 1'b0;
        retire("stall");
        tick();
        chk("stall_not_queued_out_valid", 32'(out_valid), 32'd0);
        chk("stall_not_queued_in_ready", 32'(in_ready), 32'd1);
        chk("stall_not_queued_alu_a", alu_a, 32'd1);

        // reset while in EXEC aborts the instruction
        issue(7'b0110011, 3'b000, 1'b0, 32'd9, 32'd9, 32'd0);
        chk("abort_in_exec_alu_a", alu_a, 32'd9);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_values("abort");
        tick();
        chk("abort_no_result", 32'(out_valid), 32'd0);
        chk("abort_idle", 32'(in_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
